// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr_arbiter
// Function : Round-robin arbiter with per-grant hold limit for a 4:1 lane mux.
// Revision : 1.0
// ============================================================================
module mux4_rr_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] in_data,
  input  logic               out_ready,
  output logic [3:0]         gnt,
  output logic [1:0]         sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  logic       w_win_found;
  logic [1:0] w_win_idx;
  logic [1:0] w_cand;
  logic       w_xfer;
  logic       w_hold_last;
  logic       w_take_win;

  // Wrapping priority search starting at ptr; 2-bit addition wraps 3 -> 0.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = ptr_q;
    w_cand      = '0;
    for (int k = 0; k < 4; k++) begin
      w_cand = ptr_q + k[1:0];
      if (!w_win_found && req[w_cand]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_cand;
      end
    end
  end

  assign out_valid   = |(gnt_q & req);
  assign w_xfer      = out_valid & out_ready;
  assign w_hold_last = (hold_q == CNT_W'(MAX_HOLD - 1));

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    w_take_win = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_win_found) w_take_win = 1'b1;
      end
      BUSY: begin
        // Withdrawal is checked first so it overrides the hold limit.
        if (!req[sel_q]) begin
          if (w_win_found) begin
            w_take_win = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            hold_d  = '0;
          end
        end else if (w_xfer) begin
          if (w_hold_last) w_take_win = 1'b1;
          else             hold_d     = hold_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        hold_d  = '0;
      end
    endcase
    if (w_take_win) begin
      state_d = BUSY;
      gnt_d   = 4'b0001 << w_win_idx;
      sel_d   = w_win_idx;
      ptr_d   = w_win_idx + 2'd1;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt      = gnt_q;
  assign sel      = sel_q;
  assign out_data = in_data[sel_q*WIDTH +: WIDTH];

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4_rr_arbiter
// Function : Scoreboard bench for mux4_rr_arbiter with directed vectors.
// Revision : 1.0
// ============================================================================
module tb_mux4_rr_arbiter;

  localparam int WIDTH = 8;
  localparam logic [WIDTH-1:0] LANE_DATA [4] = '{8'h3C, 8'hA5, 8'h5A, 8'hC3};

  logic               clk;
  logic               reset_n;
  logic [3:0]         req;
  logic [4*WIDTH-1:0] in_data;
  logic               out_ready;
  logic [3:0]         gnt;
  logic [1:0]         sel;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;

  int vectors     = 0;
  int miscompares = 0;
  int exp_q [$];

  mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(4), .CNT_W(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .in_data   (in_data),
    .out_ready (out_ready),
    .gnt       (gnt),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_lane(input int lane, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(lane);
  endtask

  // Each accepted transfer is popped and checked against the expected lane.
  always @(negedge clk) begin
    int lane;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_xfer", {28'd0, gnt}, 32'd0);
      end else begin
        lane = exp_q.pop_front();
        chk("xfer_sel",  {30'd0, sel},      lane);
        chk("xfer_gnt",  {28'd0, gnt},      32'd1 << lane);
        chk("xfer_data", {24'd0, out_data}, {24'd0, LANE_DATA[lane]});
      end
    end
  end

  initial begin
    in_data   = {LANE_DATA[3], LANE_DATA[2], LANE_DATA[1], LANE_DATA[0]};
    reset_n   = 1'b0;
    req       = 4'hF;
    out_ready = 1'b0;

    // Reset state with all requests high
    step(3);
    chk("rst_gnt",   {28'd0, gnt}, 32'h0);
    chk("rst_sel",   {30'd0, sel}, 32'h0);
    chk("rst_valid", {31'd0, out_valid}, 32'h0);
    chk("rst_data",  {24'd0, out_data}, {24'd0, LANE_DATA[0]});
    reset_n = 1'b1;
    step(1);
    chk("post_rst_gnt", {28'd0, gnt}, 32'h1);
    req = 4'h0;
    step(1);
    chk("idle_gnt", {28'd0, gnt}, 32'h0);

    // Single requester: regranted every 4 transfers without a gap
    req = 4'b0100;
    out_ready = 1'b1;
    push_lane(2, 12);
    step(1);
    chk("single_gnt", {28'd0, gnt}, 32'b0100);
    chk("single_sel", {30'd0, sel}, 32'd2);
    step(12);
    out_ready = 1'b0;
    chk("single_after_gnt", {28'd0, gnt}, 32'b0100);
    req = 4'h0;
    step(1);

    // All requesting from a fresh pointer: 0,1,2,3,0 with 4 transfers each
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    step(1);
    req = 4'hF;
    out_ready = 1'b1;
    push_lane(0, 4); push_lane(1, 4); push_lane(2, 4); push_lane(3, 4); push_lane(0, 4);
    step(1);
    chk("rot_first_gnt", {28'd0, gnt}, 32'b0001);
    step(20);
    out_ready = 1'b0;
    chk("rot_next_gnt", {28'd0, gnt}, 32'b0010);

    // Stall mid-burst: hold count must not advance
    push_lane(1, 4);
    out_ready = 1'b1;
    step(2);
    out_ready = 1'b0;
    step(10);
    chk("stall_gnt", {28'd0, gnt}, 32'b0010);
    chk("stall_sel", {30'd0, sel}, 32'd1);
    out_ready = 1'b1;
    step(2);
    out_ready = 1'b0;
    chk("stall_end_gnt", {28'd0, gnt}, 32'b0100);

    // Withdrawal after 2 transfers hands over directly to lane 3
    req = 4'h0;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    step(1);
    req = 4'b0010;
    step(1);
    chk("wd_gnt1", {28'd0, gnt}, 32'b0010);
    req = 4'b1010;
    out_ready = 1'b1;
    push_lane(1, 2);
    step(2);
    req = 4'b1000;
    out_ready = 1'b0;
    step(1);
    chk("wd_gnt3", {28'd0, gnt}, 32'b1000);
    chk("wd_sel3", {30'd0, sel}, 32'd3);
    req = 4'h0;
    step(1);
    chk("wd_idle_gnt",   {28'd0, gnt}, 32'h0);
    chk("wd_idle_valid", {31'd0, out_valid}, 32'h0);

    // Asynchronous reset mid-burst, off the clock edge
    req = 4'b0100;
    out_ready = 1'b1;
    push_lane(2, 2);
    step(3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_gnt",   {28'd0, gnt}, 32'h0);
    chk("areset_valid", {31'd0, out_valid}, 32'h0);
    req = 4'hF;
    out_ready = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(1);
    chk("areset_ptr_gnt", {28'd0, gnt}, 32'b0001);
    req = 4'h0;
    step(3);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
